ascii_scan_encoder: RTL and testbench
=====================================

# ascii_scan_encoder

Converts 7-bit ASCII characters into PS/2 Set 2 scan-code byte sequences (make, break, and shift/ctrl wrapping where needed) for keystroke injection. It sits between a character source (CPU/UART/test stimulus) and the PS/2 byte serializer. It is the inverse of the keyboard-receive ASCII translation path.

## Interface
- BYTE_GAP, 0: idle cycles inserted between successive bytes of one sequence (0..65535).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ascii_code  in  7  character to encode.
- ascii_valid  in  1  character offered.
- ascii_ready  out  1  encoder can accept a character (IDLE only).
- scan_code  out  8  scan byte to serializer.
- scan_valid  out  1  scan_code valid.
- scan_ready  in  1  serializer accepts byte.
- busy  out  1  sequence in progress (state != IDLE).
- unmapped  out  1  one-cycle pulse when an accepted character has no encoding.

## Operation
- The lookup table is US layout, Set 2. It is combinational, internal, and indexed by ascii_code. It yields a key code (8 bits) and a modifier of NONE, SHIFT or CTRL.
- Plain mappings: a–z; 0–9; space (0x29); `-=[]\;',./` and backtick. Enter 0x0D→0x5A, Tab 0x09→0x0D, Backspace 0x08→0x66, Esc 0x1B→0x76.
- SHIFT mappings: A–Z, `!@#$%^&*()_+{}|:"<>?~`. These use the unshifted key code with modifier SHIFT.
- Direct keys (0x08, 0x09, 0x0D, 0x1B) take precedence over ctrl encoding.
- Every other code (0x00, 0x7F, remaining controls) is unmapped.
- Sequences:
  - NONE: K, F0, K.
  - SHIFT: 12, K, F0, K, F0, 12.
  - CTRL: 14, K, F0, K, F0, 14.
- Accept occurs when ascii_valid && ascii_ready at a clock edge. On accept, key code, modifier and sequence length (3 or 6) are latched, and the byte index is cleared. Input may change after accept.
- Unmapped characters are accepted and dropped. unmapped pulses the cycle after accept, no bytes are emitted, and the encoder returns to IDLE.
- State machine:
  - IDLE: ascii_ready=1. Accept of a mapped character → EMIT. Accept of an unmapped character → DROP.
  - DROP: one cycle, unmapped=1 → IDLE.
  - EMIT: scan_valid=1 and scan_code=byte[index]. On scan_ready: if index is last → IDLE; else index+1, then → GAP if BYTE_GAP>0, else stay in EMIT.
  - GAP: 16-bit counter runs BYTE_GAP cycles with scan_valid=0 → EMIT.
- scan_code and scan_valid are registered. scan_code holds stable while scan_valid && !scan_ready.

## Timing
- Reset values: scan_code=0x00, scan_valid=0, busy=0, unmapped=0, ascii_ready=0 while reset is high. State goes to IDLE, so ascii_ready=1 in the first cycle after reset deasserts.
- Latency: the first byte is valid the cycle after accept.
- Throughput with scan_ready=1 and BYTE_GAP=0:
  - A 3-byte sequence occupies cycles 1–3 after accept; ascii_ready returns at cycle 4.
  - A 6-byte sequence returns ascii_ready at cycle 7.
  - With BYTE_GAP=G, each inter-byte gap adds G cycles; there is no gap after the last byte.
- Backpressure: scan_ready low stalls indefinitely with no timeout. scan_valid never drops once raised until the byte is accepted.
- ascii_valid while busy is ignored. ascii_ready=0, so no accept occurs.
- Reset mid-sequence aborts immediately. scan_valid=0 the next cycle and no break codes are sent. The downstream device may retain a stuck make; callers accept this.
- Accept and last-byte handshake cannot coincide, because ascii_ready is low in EMIT.

## Configuration
- Macro: ASCII_SCAN_CTRL_EN.
- Defined: codes 0x01–0x1A, excluding 0x08/0x09/0x0D, encode as CTRL with the key code of letter (code+0x60). Example: 0x03 → 14, 21, F0, 21, F0, 14.
- Undefined: those codes are unmapped (accepted, unmapped pulse, no bytes). The CTRL modifier path and the 0x14 wrap logic are absent.

## Test plan
- Plain character, scan_ready=1, BYTE_GAP=0: 'a' (0x61) → bytes 1C, F0, 1C on three consecutive cycles; ascii_ready high 4 cycles after accept.
- Shifted character: 'A' (0x41) → 12, 1C, F0, 1C, F0, 12; '!' (0x21) → 12, 16, F0, 16, F0, 12.
- Backpressure and gap, BYTE_GAP=3: Enter (0x0D) with scan_ready low for 5 cycles on byte 0 → 5A held stable; bytes separated by exactly 3 scan_valid=0 cycles; sequence 5A, F0, 5A.
- Unmapped and busy: 0x7F → unmapped pulse 1 cycle after accept, no scan_valid. A second ascii_valid during an active sequence is not accepted until ascii_ready.
- Ctrl mapping, both builds: 0x03 with ASCII_SCAN_CTRL_EN → 14, 21, F0, 21, F0, 14; without the macro → unmapped pulse, no bytes. 0x08 → 66, F0, 66 in both builds.
- Reset mid-sequence after byte 2 of 'A' → scan_valid=0 next cycle, ascii_ready=1 after reset release. Loopback through the receive translator reproduces 'a'…'z', 'A'…'Z', 0–9 and all mapped symbols.

Source files
------------

// File: rtl/ascii_scan_encoder.sv
`timescale 1ns/1ps
// ascii_scan_encoder
//   Turns a 7-bit ASCII character into a PS/2 Set 2 scan-code byte sequence
//   (US layout) for keystroke injection: K F0 K for plain keys, and the same
//   wrapped in 12 ... F0 12 (shift) or 14 ... F0 14 (ctrl) when a modifier
//   is needed. Characters without an encoding are accepted and dropped with
//   a one-cycle `unmapped` pulse.
//
// Parameters
//   BYTE_GAP     idle cycles between successive bytes of one sequence (0..65535)
// Configuration macro
//   ASCII_SCAN_CTRL_EN  when defined, 0x01..0x1A (except 0x08/0x09/0x0D)
//                       encode as ctrl+letter; otherwise they are unmapped.
// Ports
//   clk, reset    clock, synchronous active-high reset
//   ascii_code    character to encode
//   ascii_valid   character offered
//   ascii_ready   encoder idle and able to accept a character
//   scan_code     scan byte to the serializer (registered)
//   scan_valid    scan_code valid (registered)
//   scan_ready    serializer accepts the byte
//   busy          a sequence (or drop) is in progress
//   unmapped      one-cycle pulse, the cycle after accepting an unmapped code
module ascii_scan_encoder #(
  parameter int unsigned BYTE_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] ascii_code,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic       busy,
  output logic       unmapped
);

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_EMIT, S_GAP} state_e;
  typedef enum logic [1:0] {MOD_NONE, MOD_SHIFT, MOD_CTRL} mod_e;

  localparam int unsigned GAP_M1   = (BYTE_GAP > 0) ? BYTE_GAP - 1 : 0;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_M1);

  // Set 2 key code of letter n (1 = a ... 26 = z)
  function automatic logic [7:0] letter_key(input logic [4:0] n);
    case (n)
      5'd1:  return 8'h1C;  5'd2:  return 8'h32;  5'd3:  return 8'h21;
      5'd4:  return 8'h23;  5'd5:  return 8'h24;  5'd6:  return 8'h2B;
      5'd7:  return 8'h34;  5'd8:  return 8'h33;  5'd9:  return 8'h43;
      5'd10: return 8'h3B;  5'd11: return 8'h42;  5'd12: return 8'h4B;
      5'd13: return 8'h3A;  5'd14: return 8'h31;  5'd15: return 8'h44;
      5'd16: return 8'h4D;  5'd17: return 8'h15;  5'd18: return 8'h2D;
      5'd19: return 8'h1B;  5'd20: return 8'h2C;  5'd21: return 8'h3C;
      5'd22: return 8'h2A;  5'd23: return 8'h1D;  5'd24: return 8'h22;
      5'd25: return 8'h35;  5'd26: return 8'h1A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] digit_key(input logic [3:0] d);
    case (d)
      4'd0: return 8'h45;  4'd1: return 8'h16;  4'd2: return 8'h1E;
      4'd3: return 8'h26;  4'd4: return 8'h25;  4'd5: return 8'h2E;
      4'd6: return 8'h36;  4'd7: return 8'h3D;  4'd8: return 8'h3E;
      4'd9: return 8'h46;
      default: return 8'h00;
    endcase
  endfunction

  // Byte idx of the sequence for key k with modifier m
  function automatic logic [7:0] seq_byte(input logic [2:0] idx,
                                          input logic [7:0] k,
                                          input mod_e       m);
    logic [7:0] wrap;
`ifdef ASCII_SCAN_CTRL_EN
    wrap = (m == MOD_CTRL) ? 8'h14 : 8'h12;
`else
    wrap = 8'h12;
`endif
    if (m == MOD_NONE) return (idx == 3'd1) ? 8'hF0 : k;
    case (idx)
      3'd0, 3'd5: return wrap;
      3'd1, 3'd3: return k;
      default:    return 8'hF0;
    endcase
  endfunction

  // Character lookup
  logic [7:0] lk_key;
  mod_e       lk_mod;
  logic       lk_map;

  always_comb begin
    lk_key = '0;
    lk_mod = MOD_NONE;
    lk_map = 1'b0;
    if (ascii_code >= 7'h61 && ascii_code <= 7'h7A) begin
      lk_key = letter_key(ascii_code[4:0]);
      lk_map = 1'b1;
    end else if (ascii_code >= 7'h41 && ascii_code <= 7'h5A) begin
      lk_key = letter_key(ascii_code[4:0]);
      lk_mod = MOD_SHIFT;
      lk_map = 1'b1;
    end else if (ascii_code >= 7'h30 && ascii_code <= 7'h39) begin
      lk_key = digit_key(ascii_code[3:0]);
      lk_map = 1'b1;
    end else begin
      lk_map = 1'b1;
      case (ascii_code)
        // direct keys, listed here so they win over ctrl encoding
        7'h08: lk_key = 8'h66;
        7'h09: lk_key = 8'h0D;
        7'h0D: lk_key = 8'h5A;
        7'h1B: lk_key = 8'h76;
        // unshifted symbols
        7'h20: lk_key = 8'h29;
        7'h2D: lk_key = 8'h4E;
        7'h3D: lk_key = 8'h55;
        7'h5B: lk_key = 8'h54;
        7'h5D: lk_key = 8'h5B;
        7'h5C: lk_key = 8'h5D;
        7'h3B: lk_key = 8'h4C;
        7'h27: lk_key = 8'h52;
        7'h2C: lk_key = 8'h41;
        7'h2E: lk_key = 8'h49;
        7'h2F: lk_key = 8'h4A;
        7'h60: lk_key = 8'h0E;
        // shifted symbols
        7'h21: begin lk_key = 8'h16; lk_mod = MOD_SHIFT; end
        7'h40: begin lk_key = 8'h1E; lk_mod = MOD_SHIFT; end
        7'h23: begin lk_key = 8'h26; lk_mod = MOD_SHIFT; end
        7'h24: begin lk_key = 8'h25; lk_mod = MOD_SHIFT; end
        7'h25: begin lk_key = 8'h2E; lk_mod = MOD_SHIFT; end
        7'h5E: begin lk_key = 8'h36; lk_mod = MOD_SHIFT; end
        7'h26: begin lk_key = 8'h3D; lk_mod = MOD_SHIFT; end
        7'h2A: begin lk_key = 8'h3E; lk_mod = MOD_SHIFT; end
        7'h28: begin lk_key = 8'h46; lk_mod = MOD_SHIFT; end
        7'h29: begin lk_key = 8'h45; lk_mod = MOD_SHIFT; end
        7'h5F: begin lk_key = 8'h4E; lk_mod = MOD_SHIFT; end
        7'h2B: begin lk_key = 8'h55; lk_mod = MOD_SHIFT; end
        7'h7B: begin lk_key = 8'h54; lk_mod = MOD_SHIFT; end
        7'h7D: begin lk_key = 8'h5B; lk_mod = MOD_SHIFT; end
        7'h7C: begin lk_key = 8'h5D; lk_mod = MOD_SHIFT; end
        7'h3A: begin lk_key = 8'h4C; lk_mod = MOD_SHIFT; end
        7'h22: begin lk_key = 8'h52; lk_mod = MOD_SHIFT; end
        7'h3C: begin lk_key = 8'h41; lk_mod = MOD_SHIFT; end
        7'h3E: begin lk_key = 8'h49; lk_mod = MOD_SHIFT; end
        7'h3F: begin lk_key = 8'h4A; lk_mod = MOD_SHIFT; end
        7'h7E: begin lk_key = 8'h0E; lk_mod = MOD_SHIFT; end
        default: begin
          lk_map = 1'b0;
`ifdef ASCII_SCAN_CTRL_EN
          // ctrl+letter: code 0x01..0x1A uses the key of letter (code+0x60)
          if (ascii_code >= 7'h01 && ascii_code <= 7'h1A) begin
            lk_key = letter_key(ascii_code[4:0]);
            lk_mod = MOD_CTRL;
            lk_map = 1'b1;
          end
`endif
        end
      endcase
    end
  end

  // Sequencer state
  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  last_q, last_d;
  logic [7:0]  key_q, key_d;
  mod_e        mod_q, mod_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  scan_code_q, scan_code_d;
  logic        scan_valid_q, scan_valid_d;
  logic        unmapped_q, unmapped_d;
  logic        busy_q, busy_d;
  logic        ascii_ready_q, ascii_ready_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    key_d         = key_q;
    mod_d         = mod_q;
    gap_cnt_d     = gap_cnt_q;
    scan_code_d   = scan_code_q;
    scan_valid_d  = scan_valid_q;
    unmapped_d    = 1'b0;
    busy_d        = busy_q;
    ascii_ready_d = ascii_ready_q;

    case (state_q)
      S_IDLE: begin
        ascii_ready_d = 1'b1;
        busy_d        = 1'b0;
        if (ascii_valid && ascii_ready_q) begin
          ascii_ready_d = 1'b0;
          busy_d        = 1'b1;
          if (lk_map) begin
            key_d        = lk_key;
            mod_d        = lk_mod;
            last_d       = (lk_mod == MOD_NONE) ? 3'd2 : 3'd5;
            idx_d        = '0;
            scan_code_d  = seq_byte(3'd0, lk_key, lk_mod);
            scan_valid_d = 1'b1;
            state_d      = S_EMIT;
          end else begin
            unmapped_d = 1'b1;
            state_d    = S_DROP;
          end
        end
      end
      S_DROP: begin
        ascii_ready_d = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      S_EMIT: begin
        if (scan_ready) begin
          if (idx_q == last_q) begin
            scan_valid_d  = 1'b0;
            ascii_ready_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
            if (BYTE_GAP > 0) begin
              scan_valid_d = 1'b0;
              gap_cnt_d    = GAP_LOAD;
              state_d      = S_GAP;
            end else begin
              scan_code_d = seq_byte(idx_q + 3'd1, key_q, mod_q);
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          scan_code_d  = seq_byte(idx_q, key_q, mod_q);
          scan_valid_d = 1'b1;
          state_d      = S_EMIT;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      last_q        <= '0;
      key_q         <= '0;
      mod_q         <= MOD_NONE;
      gap_cnt_q     <= '0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      unmapped_q    <= 1'b0;
      busy_q        <= 1'b0;
      ascii_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      key_q         <= key_d;
      mod_q         <= mod_d;
      gap_cnt_q     <= gap_cnt_d;
      scan_code_q   <= scan_code_d;
      scan_valid_q  <= scan_valid_d;
      unmapped_q    <= unmapped_d;
      busy_q        <= busy_d;
      ascii_ready_q <= ascii_ready_d;
    end
  end

  assign ascii_ready = ascii_ready_q;
  assign scan_code   = scan_code_q;
  assign scan_valid  = scan_valid_q;
  assign busy        = busy_q;
  assign unmapped    = unmapped_q;

endmodule

// File: tb/tb_ascii_scan_encoder.sv
`timescale 1ns/1ps
// Directed bench for ascii_scan_encoder: one instance with BYTE_GAP=0 and one
// with BYTE_GAP=3. Inputs change and outputs are sampled on the falling edge.
module tb_ascii_scan_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] code0 = '0, code3 = '0;
  logic       av0 = 1'b0, av3 = 1'b0;
  logic       sr0 = 1'b1, sr3 = 1'b1;
  logic       rdy0, rdy3, sv0, sv3, busy0, busy3, unm0, unm3;
  logic [7:0] sc0, sc3;

  always #5 clk = ~clk;

  ascii_scan_encoder #(.BYTE_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .ascii_code(code0), .ascii_valid(av0),
    .ascii_ready(rdy0), .scan_code(sc0), .scan_valid(sv0),
    .scan_ready(sr0), .busy(busy0), .unmapped(unm0));

  ascii_scan_encoder #(.BYTE_GAP(3)) dut3 (
    .clk(clk), .reset(reset), .ascii_code(code3), .ascii_valid(av3),
    .ascii_ready(rdy3), .scan_code(sc3), .scan_valid(sv3),
    .scan_ready(sr3), .busy(busy3), .unmapped(unm3));

  int n_vec = 0;
  int n_mis = 0;

  // Capture of one sequence from dut0 (cycle 1 = first cycle after accept)
  logic [7:0] col_b [16];
  int         col_c [16];
  int         col_n, col_ready, col_unm_n, col_unm_c;

  // Wait (bounded) for dut0 ready, then present one character for one edge.
  task automatic offer0(input logic [6:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rdy0 === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      code0 = c;
      av0   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      av0 = 1'b0;
    end
  endtask

  // Record dut0 bytes / unmapped pulses until ascii_ready returns.
  task automatic collect0(input int limit);
    col_n = 0; col_ready = -1; col_unm_n = 0; col_unm_c = -1;
    for (int c = 1; c <= limit; c++) begin
      if (sv0 === 1'b1 && col_n < 16) begin
        col_b[col_n] = sc0; col_c[col_n] = c; col_n++;
      end
      if (unm0 === 1'b1) begin
        col_unm_n++;
        if (col_unm_c < 0) col_unm_c = c;
      end
      if (rdy0 === 1'b1) begin col_ready = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (sv0 !== 1'b0)   begin n_mis++; $display("FAIL reset_scan_valid got %b want 0", sv0); end
    n_vec++; if (sc0 !== 8'h00)  begin n_mis++; $display("FAIL reset_scan_code got %02h want 00", sc0); end
    n_vec++; if (busy0 !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy0); end
    n_vec++; if (unm0 !== 1'b0)  begin n_mis++; $display("FAIL reset_unmapped got %b want 0", unm0); end
    n_vec++; if (rdy0 !== 1'b0)  begin n_mis++; $display("FAIL reset_ready got %b want 0", rdy0); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b1)  begin n_mis++; $display("FAIL post_reset_ready0 got %b want 1", rdy0); end
    n_vec++; if (rdy3 !== 1'b1)  begin n_mis++; $display("FAIL post_reset_ready3 got %b want 1", rdy3); end
  endtask

  task automatic test_plain;
    logic [6:0] pc [12] = '{7'h61, 7'h7A, 7'h30, 7'h35, 7'h20, 7'h60,
                            7'h5C, 7'h27, 7'h0D, 7'h1B, 7'h09, 7'h08};
    logic [7:0] pk [12] = '{8'h1C, 8'h1A, 8'h45, 8'h2E, 8'h29, 8'h0E,
                            8'h5D, 8'h52, 8'h5A, 8'h76, 8'h0D, 8'h66};
    logic [7:0] eb [3];
    bit ok;
    for (int t = 0; t < 12; t++) begin
      eb = '{pk[t], 8'hF0, pk[t]};
      offer0(pc[t], ok);
      n_vec++; if (!ok) begin n_mis++; $display("FAIL plain_accept[%02h] got not-ready want ready", pc[t]); end
      collect0(20);
      n_vec++; if (col_n != 3) begin n_mis++; $display("FAIL plain_count[%02h] got %0d want 3", pc[t], col_n); end
      for (int j = 0; j < 3 && j < col_n; j++) begin
        n_vec++;
        if (col_b[j] !== eb[j] || col_c[j] != j + 1) begin
          n_mis++;
          $display("FAIL plain_byte[%02h][%0d] got %02h@%0d want %02h@%0d", pc[t], j, col_b[j], col_c[j], eb[j], j + 1);
        end
      end
      n_vec++; if (col_ready != 4) begin n_mis++; $display("FAIL plain_ready[%02h] got cycle %0d want 4", pc[t], col_ready); end
      n_vec++; if (col_unm_n != 0) begin n_mis++; $display("FAIL plain_unmapped[%02h] got %0d want 0", pc[t], col_unm_n); end
    end
  endtask

  task automatic test_shift;
    logic [6:0] pc [8] = '{7'h41, 7'h21, 7'h5A, 7'h3F, 7'h7E, 7'h22, 7'h29, 7'h40};
    logic [7:0] pk [8] = '{8'h1C, 8'h16, 8'h1A, 8'h4A, 8'h0E, 8'h52, 8'h45, 8'h1E};
    logic [7:0] eb [6];
    bit ok;
    for (int t = 0; t < 8; t++) begin
      eb = '{8'h12, pk[t], 8'hF0, pk[t], 8'hF0, 8'h12};
      offer0(pc[t], ok);
      n_vec++; if (!ok) begin n_mis++; $display("FAIL shift_accept[%02h] got not-ready want ready", pc[t]); end
      collect0(20);
      n_vec++; if (col_n != 6) begin n_mis++; $display("FAIL shift_count[%02h] got %0d want 6", pc[t], col_n); end
      for (int j = 0; j < 6 && j < col_n; j++) begin
        n_vec++;
        if (col_b[j] !== eb[j] || col_c[j] != j + 1) begin
          n_mis++;
          $display("FAIL shift_byte[%02h][%0d] got %02h@%0d want %02h@%0d", pc[t], j, col_b[j], col_c[j], eb[j], j + 1);
        end
      end
      n_vec++; if (col_ready != 7) begin n_mis++; $display("FAIL shift_ready[%02h] got cycle %0d want 7", pc[t], col_ready); end
    end
  endtask

  // Unmapped codes; the ctrl-range ones depend on the build.
  task automatic test_unmapped_ctrl;
    logic [6:0] pc [5] = '{7'h7F, 7'h00, 7'h1F, 7'h03, 7'h1A};
    logic [7:0] pk [5] = '{8'h00, 8'h00, 8'h00, 8'h21, 8'h1A};
    logic [7:0] eb [6];
    bit ok, is_ctrl;
    for (int t = 0; t < 5; t++) begin
`ifdef ASCII_SCAN_CTRL_EN
      is_ctrl = (t >= 3);
`else
      is_ctrl = 1'b0;
`endif
      eb = '{8'h14, pk[t], 8'hF0, pk[t], 8'hF0, 8'h14};
      offer0(pc[t], ok);
      n_vec++; if (!ok) begin n_mis++; $display("FAIL unm_accept[%02h] got not-ready want ready", pc[t]); end
      collect0(20);
      if (is_ctrl) begin
        n_vec++; if (col_n != 6) begin n_mis++; $display("FAIL ctrl_count[%02h] got %0d want 6", pc[t], col_n); end
        for (int j = 0; j < 6 && j < col_n; j++) begin
          n_vec++;
          if (col_b[j] !== eb[j] || col_c[j] != j + 1) begin
            n_mis++;
            $display("FAIL ctrl_byte[%02h][%0d] got %02h@%0d want %02h@%0d", pc[t], j, col_b[j], col_c[j], eb[j], j + 1);
          end
        end
        n_vec++; if (col_unm_n != 0) begin n_mis++; $display("FAIL ctrl_unmapped[%02h] got %0d want 0", pc[t], col_unm_n); end
        n_vec++; if (col_ready != 7) begin n_mis++; $display("FAIL ctrl_ready[%02h] got cycle %0d want 7", pc[t], col_ready); end
      end else begin
        n_vec++; if (col_n != 0) begin n_mis++; $display("FAIL unm_bytes[%02h] got %0d want 0", pc[t], col_n); end
        n_vec++; if (col_unm_n != 1 || col_unm_c != 1) begin
          n_mis++; $display("FAIL unm_pulse[%02h] got %0d@%0d want 1@1", pc[t], col_unm_n, col_unm_c);
        end
        n_vec++; if (col_ready != 2) begin n_mis++; $display("FAIL unm_ready[%02h] got cycle %0d want 2", pc[t], col_ready); end
      end
    end
  endtask

  // Second character held valid while busy is taken only once ready returns.
  task automatic test_back_to_back;
    logic [7:0] eb [6] = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32};
    int         ec [6] = '{1, 2, 3, 5, 6, 7};
    int acc;
    bit ok;
    offer0(7'h61, ok);
    n_vec++; if (!ok) begin n_mis++; $display("FAIL b2b_accept got not-ready want ready"); end
    code0 = 7'h62; av0 = 1'b1; acc = -1; col_n = 0;
    for (int c = 1; c <= 20; c++) begin
      if (acc > 0) av0 = 1'b0;
      if (sv0 === 1'b1 && col_n < 16) begin col_b[col_n] = sc0; col_c[col_n] = c; col_n++; end
      if (c <= 3) begin
        n_vec++;
        if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin
          n_mis++; $display("FAIL b2b_busy[%0d] got rdy=%b busy=%b want rdy=0 busy=1", c, rdy0, busy0);
        end
      end
      if (acc > 0 && c > acc && rdy0 === 1'b1) break;
      if (acc < 0 && rdy0 === 1'b1) acc = c;
      @(negedge clk);
    end
    av0 = 1'b0;
    n_vec++; if (acc != 4) begin n_mis++; $display("FAIL b2b_accept_cycle got %0d want 4", acc); end
    n_vec++; if (col_n != 6) begin n_mis++; $display("FAIL b2b_count got %0d want 6", col_n); end
    for (int j = 0; j < 6 && j < col_n; j++) begin
      n_vec++;
      if (col_b[j] !== eb[j] || col_c[j] != ec[j]) begin
        n_mis++; $display("FAIL b2b_byte[%0d] got %02h@%0d want %02h@%0d", j, col_b[j], col_c[j], eb[j], ec[j]);
      end
    end
  endtask

  // Enter on the BYTE_GAP=3 instance with byte 0 stalled.
  task automatic test_gap_backpressure;
    logic       ev [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ecd [15] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00,
                             8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00};
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rdy3 === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!ok) begin n_mis++; $display("FAIL gap_accept got not-ready want ready"); end
    code3 = 7'h0D; av3 = 1'b1; sr3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    av3 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      n_vec++;
      if (sv3 !== ev[c-1]) begin n_mis++; $display("FAIL gap_valid[%0d] got %b want %b", c, sv3, ev[c-1]); end
      if (ev[c-1]) begin
        n_vec++;
        if (sc3 !== ecd[c-1]) begin n_mis++; $display("FAIL gap_code[%0d] got %02h want %02h", c, sc3, ecd[c-1]); end
      end
      n_vec++;
      if (rdy3 !== (c == 15) || busy3 !== (c != 15)) begin
        n_mis++; $display("FAIL gap_ready[%0d] got rdy=%b busy=%b want rdy=%b busy=%b", c, rdy3, busy3, c == 15, c != 15);
      end
      if (c == 6) sr3 = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    offer0(7'h41, ok);
    n_vec++; if (!ok) begin n_mis++; $display("FAIL rmid_accept got not-ready want ready"); end
    n_vec++; if (sv0 !== 1'b1 || sc0 !== 8'h12) begin n_mis++; $display("FAIL rmid_byte0 got %b/%02h want 1/12", sv0, sc0); end
    @(negedge clk);
    n_vec++; if (sv0 !== 1'b1 || sc0 !== 8'h1C) begin n_mis++; $display("FAIL rmid_byte1 got %b/%02h want 1/1C", sv0, sc0); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (sv0 !== 1'b0) begin n_mis++; $display("FAIL rmid_valid got %b want 0", sv0); end
    n_vec++; if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin
      n_mis++; $display("FAIL rmid_state got busy=%b rdy=%b want busy=0 rdy=0", busy0, rdy0);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b1 || sv0 !== 1'b0) begin
      n_mis++; $display("FAIL rmid_release got rdy=%b valid=%b want rdy=1 valid=0", rdy0, sv0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plain();
    test_shift();
    test_unmapped_ctrl();
    test_back_to_back();
    test_gap_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
